// File: rtl/hero_motion_ctrl.sv
// hero_motion_ctrl: per-frame hero stepping (x then y) with collision rollback, plus bomb timer.
// Optional HERO_GRAVITY_EN: adds a constant downward pull to every y step unless up is held.
module hero_motion_ctrl #(
  parameter int STEP_X           = 2,
  parameter int STEP_Y           = 2,
  parameter int SETTLE_CYC       = 3,
  parameter int BOMB_STEP_FRAMES = 20,
  parameter int BOMB_DROP_Y      = 18,
  parameter int GRAVITY          = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       level_start,
  input  logic [9:0] start_x,
  input  logic [9:0] start_y,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       f_key,
  input  logic       coll,
  output logic [9:0] char_pos_x,
  output logic [9:0] char_pos_y,
  output logic [9:0] bomb_pos_x,
  output logic [9:0] bomb_pos_y,
  output logic [3:0] b_cnt,
  output logic       busy,
  output logic       explode
);

  localparam logic [10:0] X_MAX = 11'd639;
  localparam logic [11:0] Y_MAX = 12'd479;
`ifdef HERO_GRAVITY_EN
  localparam int Y_PULL = GRAVITY;
`else
  localparam int Y_PULL = 0 * GRAVITY;
`endif
  localparam int BF_W = $clog2(BOMB_STEP_FRAMES + 1);

  typedef enum logic [2:0] {S_IDLE, S_STEP_X, S_CHK_X, S_STEP_Y, S_CHK_Y} state_t;

  state_t      r_state, w_state_next;
  logic [9:0]  r_x, r_y, r_prev_x, r_prev_y;
  logic [9:0]  w_x_next, w_y_next, w_prev_x_next, w_prev_y_next;
  logic [3:0]  r_settle, w_settle_next;
  logic [9:0]  w_x_step, w_y_step;
  logic [10:0] w_x_sum;
  logic [11:0] w_y_sum;
  logic        w_settle_done;

  logic [9:0]      r_bomb_x, r_bomb_y;
  logic [3:0]      r_b_cnt;
  logic [BF_W-1:0] r_bomb_frames;
  logic            r_f_prev, r_explode;
  logic            w_f_rise, w_bomb_wrap;

  assign w_x_sum       = {1'b0, r_x} + 11'(STEP_X);
  // Downward move: pull (zero without gravity) plus the down-key step.
  assign w_y_sum       = {2'b00, r_y} + 12'(Y_PULL) + (key_down ? 12'(STEP_Y) : 12'd0);
  assign w_settle_done = (r_settle == 4'(SETTLE_CYC - 1));

  always_comb begin
    w_x_step = r_x;
    if (key_left && !key_right) begin
      if (r_x >= 10'(STEP_X)) w_x_step = r_x - 10'(STEP_X);
    end else if (key_right && !key_left) begin
      if (w_x_sum <= X_MAX) w_x_step = w_x_sum[9:0];
    end
  end

  always_comb begin
    w_y_step = r_y;
    if (key_up && !key_down) begin
      if (r_y >= 10'(STEP_Y)) w_y_step = r_y - 10'(STEP_Y);
    end else if (!key_up) begin
      if (w_y_sum <= Y_MAX) w_y_step = w_y_sum[9:0];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_prev_x_next = r_prev_x;
    w_prev_y_next = r_prev_y;
    w_settle_next = r_settle;
    if (level_start) begin
      w_x_next      = start_x;
      w_y_next      = start_y;
      w_settle_next = 4'd0;
      w_state_next  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (frame_tick) w_state_next = S_STEP_X;
        S_STEP_X: begin
          w_prev_x_next = r_x;
          w_x_next      = w_x_step;
          w_settle_next = 4'd0;
          w_state_next  = S_CHK_X;
        end
        S_CHK_X: begin
          if (w_settle_done) begin
            if (coll) w_x_next = r_prev_x;
            w_settle_next = 4'd0;
            w_state_next  = S_STEP_Y;
          end else begin
            w_settle_next = r_settle + 4'd1;
          end
        end
        S_STEP_Y: begin
          w_prev_y_next = r_y;
          w_y_next      = w_y_step;
          w_settle_next = 4'd0;
          w_state_next  = S_CHK_Y;
        end
        S_CHK_Y: begin
          if (w_settle_done) begin
            if (coll) w_y_next = r_prev_y;
            w_settle_next = 4'd0;
            w_state_next  = S_IDLE;
          end else begin
            w_settle_next = r_settle + 4'd1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= 10'd320;
      r_y      <= 10'd240;
      r_prev_x <= 10'd0;
      r_prev_y <= 10'd0;
      r_settle <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_prev_x <= w_prev_x_next;
      r_prev_y <= w_prev_y_next;
      r_settle <= w_settle_next;
    end
  end

  assign w_f_rise    = f_key & ~r_f_prev;
  assign w_bomb_wrap = (r_bomb_frames == BF_W'(BOMB_STEP_FRAMES - 1));

  // Drop only from idle (b_cnt 0); the frame counter runs only while a bomb is live,
  // so a key edge can never collide with the 3->0 return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bomb_x      <= 10'd0;
      r_bomb_y      <= 10'd0;
      r_b_cnt       <= 4'd0;
      r_bomb_frames <= '0;
      r_f_prev      <= 1'b0;
      r_explode     <= 1'b0;
    end else begin
      r_f_prev  <= f_key;
      r_explode <= 1'b0;
      if (level_start) begin
        r_b_cnt       <= 4'd0;
        r_bomb_frames <= '0;
      end else if (r_b_cnt == 4'd0) begin
        if (w_f_rise) begin
          r_bomb_x      <= r_x;
          r_bomb_y      <= r_y + 10'(BOMB_DROP_Y);
          r_b_cnt       <= 4'd1;
          r_bomb_frames <= '0;
        end
      end else if (frame_tick) begin
        if (w_bomb_wrap) begin
          r_bomb_frames <= '0;
          if (r_b_cnt == 4'd3) begin
            r_b_cnt <= 4'd0;
          end else begin
            r_b_cnt <= r_b_cnt + 4'd1;
            if (r_b_cnt == 4'd2) r_explode <= 1'b1;
          end
        end else begin
          r_bomb_frames <= r_bomb_frames + BF_W'(1);
        end
      end
    end
  end

  assign char_pos_x = r_x;
  assign char_pos_y = r_y;
  assign bomb_pos_x = r_bomb_x;
  assign bomb_pos_y = r_bomb_y;
  assign b_cnt      = r_b_cnt;
  assign busy       = (r_state != S_IDLE);
  assign explode    = r_explode;

endmodule

// File: tb/tb_hero_motion_ctrl.sv
// Bench for hero_motion_ctrl: frame-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_hero_motion_ctrl;

  localparam int SETTLE = 3;
  localparam int BSF    = 20;
  localparam int DROP   = 18;
`ifdef HERO_GRAVITY_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0, level_start = 1'b0;
  logic [9:0] start_x = 10'd0, start_y = 10'd0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic       f_key = 1'b0, coll = 1'b0;
  logic [9:0] char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y;
  logic [3:0] b_cnt;
  logic       busy, explode;

  hero_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .level_start(level_start),
    .start_x(start_x), .start_y(start_y),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .f_key(f_key), .coll(coll),
    .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .bomb_pos_x(bomb_pos_x), .bomb_pos_y(bomb_pos_y),
    .b_cnt(b_cnt), .busy(busy), .explode(explode)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_explode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: spec rules as plain integer arithmetic on a frame timeline.
  int m_x, m_y, m_bx, m_by, m_b, m_bf, m_age, m_px, m_py;
  bit m_fprev, m_exp, m_rise;

  function automatic int move_x(int p, bit l, bit r);
    if (l && !r) return (p >= 2) ? p - 2 : p;
    if (r && !l) return (p + 2 <= 639) ? p + 2 : p;
    return p;
  endfunction

  function automatic int move_y(int p, bit u, bit d);
    int s;
    if (u && !d) return (p >= 2) ? p - 2 : p;
    if (u) return p;
    s = G + (d ? 2 : 0);
    return (p + s <= 479) ? p + s : p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_x = 320; m_y = 240; m_bx = 0; m_by = 0; m_b = 0; m_bf = 0;
      m_age = 0; m_px = 0; m_py = 0; m_fprev = 0; m_exp = 0;
    end else begin
      m_rise  = f_key && !m_fprev;
      m_fprev = f_key;
      m_exp   = 0;
      if (level_start) begin
        m_x = start_x; m_y = start_y; m_b = 0; m_bf = 0; m_age = 0;
      end else begin
        if (m_b == 0) begin
          if (m_rise) begin
            m_bx = m_x; m_by = (m_y + DROP) % 1024; m_b = 1; m_bf = 0;
          end
        end else if (frame_tick) begin
          m_bf++;
          if (m_bf == BSF) begin
            m_bf  = 0;
            m_b   = (m_b + 1) % 4;
            m_exp = (m_b == 3);
          end
        end
        // m_age = clocks since the accepted frame_tick; sequence ends at 2*(SETTLE+1).
        if (m_age == 0) begin
          if (frame_tick) m_age = 1;
        end else begin
          if (m_age == 1) begin
            m_px = m_x; m_x = move_x(m_x, key_left, key_right);
          end else if (m_age == SETTLE + 1) begin
            if (coll) m_x = m_px;
          end else if (m_age == SETTLE + 2) begin
            m_py = m_y; m_y = move_y(m_y, key_up, key_down);
          end else if (m_age == 2 * SETTLE + 2) begin
            if (coll) m_y = m_py;
          end
          m_age = (m_age == 2 * SETTLE + 2) ? 0 : m_age + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_char_x", 32'(char_pos_x), 32'(m_x));
      check("cyc_char_y", 32'(char_pos_y), 32'(m_y));
      check("cyc_bomb_x", 32'(bomb_pos_x), 32'(m_bx));
      check("cyc_bomb_y", 32'(bomb_pos_y), 32'(m_by));
      check("cyc_b_cnt", 32'(b_cnt), 32'(m_b));
      check("cyc_busy", 32'(busy), 32'(m_age != 0));
      check("cyc_explode", 32'(explode), 32'(m_exp));
      if (explode) n_explode++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(11);
  endtask

  task automatic lstart(input int x, input int y);
    start_x = 10'(x); start_y = 10'(y); level_start = 1'b1; cyc(1); level_start = 1'b0;
  endtask

  task automatic fpulse();
    f_key = 1'b1; cyc(2); f_key = 1'b0; cyc(1);
  endtask

  function automatic int pick(input int max);
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 1;
      2: return max - 1;
      3: return max;
      default: return $urandom_range(0, max);
    endcase
  endfunction

  int e0;

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("reset_x", 32'(char_pos_x), 320);
    check("reset_y", 32'(char_pos_y), 240);
    check("reset_bomb_x", 32'(bomb_pos_x), 0);
    check("reset_bomb_y", 32'(bomb_pos_y), 0);
    check("reset_b_cnt", 32'(b_cnt), 0);
    check("reset_busy", 32'(busy), 0);

    // Idle frames: busy high from the clock after the tick for 8 clocks, low 9 clocks after.
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check("busy_first", 32'(busy), 1);
      cyc(7);
      check("busy_last", 32'(busy), 1);
      cyc(1);
      check("busy_fall", 32'(busy), 0);
      cyc(2);
    end
    check("idle_x", 32'(char_pos_x), 320);
    check("idle_y", 32'(char_pos_y), 32'(240 + 3 * G));
    check("idle_b_cnt", 32'(b_cnt), 0);

    lstart(100, 200);
    key_right = 1'b1;
    repeat (5) frame();
    check("right5_x", 32'(char_pos_x), 110);
    check("right5_y", 32'(char_pos_y), 32'(200 + 5 * G));

    // Collision only while x is being checked.
    lstart(100, 200);
    coll = 1'b1; frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(4);
    coll = 1'b0; cyc(7);
    check("coll_x_rollback", 32'(char_pos_x), 100);
    check("coll_y_kept", 32'(char_pos_y), 32'(200 + G));
    frame();
    check("coll_clear_x", 32'(char_pos_x), 102);
    key_right = 1'b0;

    lstart(1, 200); key_left = 1'b1; frame(); key_left = 1'b0;
    check("underflow_x", 32'(char_pos_x), 1);
    lstart(639, 200); key_right = 1'b1; frame(); key_right = 1'b0;
    check("overflow_x", 32'(char_pos_x), 639);
    lstart(300, 0); key_up = 1'b1; frame(); key_up = 1'b0;
    check("underflow_y", 32'(char_pos_y), 0);
    lstart(300, 479); key_down = 1'b1; frame(); key_down = 1'b0;
    check("overflow_y", 32'(char_pos_y), 479);

    lstart(300, 150);
    fpulse();
    check("drop_bx", 32'(bomb_pos_x), 300);
    check("drop_by", 32'(bomb_pos_y), 168);
    check("drop_b_cnt", 32'(b_cnt), 1);
    e0 = n_explode;
    for (int f = 1; f <= 60; f++) begin
      frame();
      if (f == 10) fpulse();
      if (f == 19) check("bomb_f19", 32'(b_cnt), 1);
      if (f == 20) check("bomb_f20", 32'(b_cnt), 2);
      if (f == 39) check("bomb_f39", 32'(b_cnt), 2);
      if (f == 40) check("bomb_f40", 32'(b_cnt), 3);
      if (f == 40) check("explode_once", 32'(n_explode - e0), 1);
      if (f == 59) check("bomb_f59", 32'(b_cnt), 3);
      if (f == 60) check("bomb_f60", 32'(b_cnt), 0);
    end
    check("refire_ignored_bx", 32'(bomb_pos_x), 300);
    check("refire_ignored_by", 32'(bomb_pos_y), 168);

    lstart(200, 100);
    fpulse();
    repeat (20) frame();
    check("pre_abort_b_cnt", 32'(b_cnt), 2);
    key_right = 1'b1;
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(5);
    check("in_chk_y_busy", 32'(busy), 1);
    lstart(50, 60);
    check("abort_x", 32'(char_pos_x), 50);
    check("abort_y", 32'(char_pos_y), 60);
    check("abort_busy", 32'(busy), 0);
    check("abort_b_cnt", 32'(b_cnt), 0);
    key_right = 1'b0;
    cyc(2);

    // Randomized soak; the per-cycle compare does the checking.
    for (int c = 0; c < 9000; c++) begin
      if ($urandom_range(0, 15) == 0) {key_left, key_right, key_up, key_down} = 4'($urandom);
      coll       = ($urandom_range(0, 3) == 0);
      frame_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) f_key = ~f_key;
      level_start = ($urandom_range(0, 1499) == 0);
      if (level_start) begin
        start_x = 10'(pick(639));
        start_y = 10'(pick(479));
      end
      cyc(1);
    end
    {key_left, key_right, key_up, key_down} = 4'b0;
    coll = 1'b0; frame_tick = 1'b0; f_key = 1'b0; level_start = 1'b0;
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
